// File: rtl/mod_hi_speed_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// mod_hi_speed_ram_arbiter_if
//   Bundles the three requester ports (RX writer, TX reader, host R/W), the
//   single-port buffer RAM port and the GRANT status into one interface.
//   slave  : the arbiter's view (takes REQs/addresses/RAM_RDATA, drives RDYs,
//            read data, RAM address/data/WE and GRANT).
//   master : the environment's view (requesters plus the RAM itself).
// -----------------------------------------------------------------------------
interface mod_hi_speed_ram_arbiter_if;
  // RX writer
  logic        RX_RAM_REQ_WR;
  logic        RX_RAM_RDY_WR;
  logic [15:0] RX_RAM_ADDR;
  logic [7:0]  RX_RAM_DATA;
  // TX reader
  logic        TX_RAM_REQ_RD;
  logic        TX_RAM_RDY_RD;
  logic [15:0] TX_RAM_ADDR;
  logic [7:0]  TX_RAM_DATA;
  // Host read/write
  logic        HOST_REQ;
  logic        HOST_WE;
  logic [15:0] HOST_ADDR;
  logic [7:0]  HOST_WDATA;
  logic [7:0]  HOST_RDATA;
  logic        HOST_RDY;
  // Buffer RAM
  logic [15:0] RAM_ADDR;
  logic [7:0]  RAM_WDATA;
  logic        RAM_WE;
  logic [7:0]  RAM_RDATA;
  // Current owner: 0 none, 1 RX, 2 TX, 3 HOST
  logic [1:0]  GRANT;

  modport slave (
    input  RX_RAM_REQ_WR, RX_RAM_ADDR, RX_RAM_DATA,
    input  TX_RAM_REQ_RD, TX_RAM_ADDR,
    input  HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
    input  RAM_RDATA,
    output RX_RAM_RDY_WR, TX_RAM_RDY_RD, TX_RAM_DATA,
    output HOST_RDATA, HOST_RDY,
    output RAM_ADDR, RAM_WDATA, RAM_WE, GRANT
  );

  modport master (
    output RX_RAM_REQ_WR, RX_RAM_ADDR, RX_RAM_DATA,
    output TX_RAM_REQ_RD, TX_RAM_ADDR,
    output HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
    output RAM_RDATA,
    input  RX_RAM_RDY_WR, TX_RAM_RDY_RD, TX_RAM_DATA,
    input  HOST_RDATA, HOST_RDY,
    input  RAM_ADDR, RAM_WDATA, RAM_WE, GRANT
  );
endinterface

// File: rtl/mod_hi_speed_ram_arbiter.sv
// -----------------------------------------------------------------------------
// mod_hi_speed_ram_arbiter
//   Shares one single-port synchronous buffer RAM between the hi-speed RX
//   writer, the hi-speed TX reader and the host port. One access at a time:
//   IDLE -> ACCESS -> [WAIT] -> DONE -> GAP -> IDLE.
//
// Parameters
//   RD_LAT  : RAM read latency, 1..3. The ACCESS cycle (address on the RAM)
//             counts as the first latency cycle; RAM_RDATA must be valid by
//             the end of cycle RD_LAT and is captured on that edge.
//   RX_BASE : offset added to RX_RAM_ADDR (16-bit, carry dropped)
//   TX_BASE : offset added to TX_RAM_ADDR (16-bit, carry dropped)
//
// Ports
//   CLK   : system clock
//   RESET : asynchronous, active-low reset; aborts any access in flight
//   bus   : mod_hi_speed_ram_arbiter_if.slave (requester REQ/RDY handshakes,
//           RAM port, GRANT)
//
// Configuration
//   HS_ARB_ROUND_ROBIN_EN defined : round-robin RX -> TX -> HOST -> RX,
//                                   search starts after the last winner.
//   undefined                     : fixed priority RX > TX > HOST.
// -----------------------------------------------------------------------------
module mod_hi_speed_ram_arbiter #(
  parameter int unsigned RD_LAT  = 2,
  parameter logic [15:0] RX_BASE = 16'h0000,
  parameter logic [15:0] TX_BASE = 16'h0800
) (
  input logic                        CLK,
  input logic                        RESET,
  mod_hi_speed_ram_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_WAIT, S_DONE, S_GAP
  } state_t;

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P_RX   = 2'd1;
  localparam logic [1:0] P_TX   = 2'd2;
  localparam logic [1:0] P_HOST = 2'd3;

  // WAIT lasts RD_LAT-1 cycles: counter runs 0 .. RD_LAT-2.
  localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t      state_reg, state_next;
  logic [1:0]  grant_reg;
  logic [1:0]  win_port;
  logic [15:0] ram_addr_reg;
  logic [7:0]  ram_wdata_reg;
  logic        ram_we_reg;
  logic        is_read_reg;
  logic [1:0]  wait_cnt_reg;
  logic [7:0]  tx_data_reg;
  logic [7:0]  host_rdata_reg;
  logic        rx_rdy, tx_rdy, host_rdy;
  logic [3:0]  req_vec;

  // Indexed by port id so the arbiter can use the GRANT encoding directly.
  assign req_vec = {bus.HOST_REQ, bus.TX_RAM_REQ_RD, bus.RX_RAM_REQ_WR, 1'b0};

`ifdef HS_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_first_reg;   // port searched first on the next IDLE pass
  logic [2:0] cand_port;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      rr_first_reg <= P_RX;
    else if (state_reg == S_IDLE && win_port != P_NONE)
      rr_first_reg <= (win_port == P_HOST) ? P_RX : win_port + 2'd1;
  end

  // Walk the three ports from last to first in search order so the earliest
  // requesting port in the rotation is the final assignment.
  always_comb begin
    win_port  = P_NONE;
    cand_port = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      cand_port = {1'b0, rr_first_reg} + 3'(k);
      if (cand_port > 3'd3)
        cand_port = cand_port - 3'd3;
      if (req_vec[cand_port[1:0]])
        win_port = cand_port[1:0];
    end
  end
`else
  always_comb begin
    if (req_vec[1])      win_port = P_RX;
    else if (req_vec[2]) win_port = P_TX;
    else if (req_vec[3]) win_port = P_HOST;
    else                 win_port = P_NONE;
  end
`endif

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (win_port != P_NONE) state_next = S_ACCESS;
      S_ACCESS: begin
        if (!is_read_reg || RD_LAT <= 1) state_next = S_DONE;
        else                             state_next = S_WAIT;
      end
      S_WAIT:   if (wait_cnt_reg == WAIT_LAST) state_next = S_DONE;
      S_DONE:   state_next = S_GAP;
      S_GAP:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output logic: the owner's RDY is high for the single DONE cycle.
  always_comb begin
    rx_rdy   = 1'b0;
    tx_rdy   = 1'b0;
    host_rdy = 1'b0;
    if (state_reg == S_DONE) begin
      rx_rdy   = (grant_reg == P_RX);
      tx_rdy   = (grant_reg == P_TX);
      host_rdy = (grant_reg == P_HOST);
    end
  end

  // Access datapath: requester inputs are sampled only on the grant edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      grant_reg      <= P_NONE;
      ram_addr_reg   <= 16'h0000;
      ram_wdata_reg  <= 8'h00;
      ram_we_reg     <= 1'b0;
      is_read_reg    <= 1'b0;
      wait_cnt_reg   <= 2'd0;
      tx_data_reg    <= 8'h00;
      host_rdata_reg <= 8'h00;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (win_port != P_NONE) begin
            grant_reg   <= win_port;
            is_read_reg <= (win_port == P_TX) || (win_port == P_HOST && !bus.HOST_WE);
            ram_we_reg  <= (win_port == P_RX) || (win_port == P_HOST && bus.HOST_WE);
            case (win_port)
              P_RX: begin
                ram_addr_reg  <= bus.RX_RAM_ADDR + RX_BASE;
                ram_wdata_reg <= bus.RX_RAM_DATA;
              end
              P_TX:    ram_addr_reg <= bus.TX_RAM_ADDR + TX_BASE;
              default: begin
                ram_addr_reg  <= bus.HOST_ADDR;
                ram_wdata_reg <= bus.HOST_WDATA;
              end
            endcase
          end
        end
        S_ACCESS: begin
          ram_we_reg   <= 1'b0;
          wait_cnt_reg <= 2'd0;
        end
        S_WAIT:   wait_cnt_reg <= wait_cnt_reg + 2'd1;
        S_DONE:   grant_reg <= P_NONE;   // GRANT is 0 from GAP onwards
        default:  ;
      endcase

      // Read data is captured on the edge that enters DONE and held after.
      if (state_reg != S_DONE && state_next == S_DONE && is_read_reg) begin
        if (grant_reg == P_TX) tx_data_reg    <= bus.RAM_RDATA;
        else                   host_rdata_reg <= bus.RAM_RDATA;
      end
    end
  end

  assign bus.RX_RAM_RDY_WR = rx_rdy;
  assign bus.TX_RAM_RDY_RD = tx_rdy;
  assign bus.HOST_RDY      = host_rdy;
  assign bus.TX_RAM_DATA   = tx_data_reg;
  assign bus.HOST_RDATA    = host_rdata_reg;
  assign bus.RAM_ADDR      = ram_addr_reg;
  assign bus.RAM_WDATA     = ram_wdata_reg;
  assign bus.RAM_WE        = ram_we_reg;
  assign bus.GRANT         = grant_reg;

endmodule
